// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter: serves write-through stores and 8-word I/D block
// fills on one pipelined memory port, priority store > D fill > I fill.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        d_wr_ack,
  output logic        i_fill_valid,
  output logic        d_fill_valid,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        busy,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid
);

  typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t      state, state_nxt;
  owner_t      owner;
  logic [11:0] base;
  logic [2:0]  issue_cnt;
  logic        issue_done;
  logic [2:0]  ret_cnt;

  logic        grant_wr, grant_d, grant_i;
  logic [15:0] miss_addr;
  logic        ret_valid, last_ret;

  // Block offsets of the miss addresses are meaningless: fills always start at word 0.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_miss_addr[3:0], d_miss_addr[3:0]};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    grant_wr  = 1'b0;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    if (state == IDLE) begin
      grant_wr = d_wr_req;
      grant_d  = !d_wr_req && d_miss;
      grant_i  = !d_wr_req && !d_miss && i_miss;
    end
    miss_addr = grant_d ? d_miss_addr : i_miss_addr;
    ret_valid = (state == FILL) && mem_data_valid;
    last_ret  = ret_valid && (ret_cnt == 3'd7);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_wr) state_nxt = WRITE;
               else if (grant_d || grant_i) state_nxt = FILL;
      WRITE:   state_nxt = IDLE;
      FILL:    if (last_ret) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    d_wr_ack     = (state == WRITE);
    i_fill_valid = ret_valid && (owner == OWN_I);
    d_fill_valid = ret_valid && (owner == OWN_D);
    i_fill_done  = last_ret && (owner == OWN_I);
    d_fill_done  = last_ret && (owner == OWN_D);
    fill_data    = mem_data_out;
    fill_word    = ret_cnt;
  end

  // NOTE: reset is sampled on the clock edge (synchronous); all state uses <= so
  // every register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner       <= OWN_I;
      base        <= '0;
      issue_cnt   <= '0;
      issue_done  <= 1'b0;
      ret_cnt     <= '0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          if (grant_wr) begin
            mem_en      <= 1'b1;
            mem_wr      <= 1'b1;
            mem_addr    <= d_wr_addr;
            mem_data_in <= d_wr_data;
          end else if (grant_d || grant_i) begin
            // Word 0 is issued straight from the grant; the counter holds the next word.
            owner      <= grant_d ? OWN_D : OWN_I;
            base       <= miss_addr[15:4];
            mem_en     <= 1'b1;
            mem_addr   <= {miss_addr[15:4], 4'h0};
            issue_cnt  <= 3'd1;
            issue_done <= 1'b0;
            ret_cnt    <= '0;
          end
        end
        WRITE: begin
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
        end
        FILL: begin
          if (!issue_done) begin
            mem_en    <= 1'b1;
            mem_addr  <= {base, issue_cnt, 1'b0};
            issue_cnt <= issue_cnt + 3'd1;
            if (issue_cnt == 3'd7) issue_done <= 1'b1;
          end else begin
            mem_en <= 1'b0;
          end
          // Wraps to 0 on the eighth return, leaving the counter clean for IDLE.
          if (ret_valid) ret_cnt <= ret_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: pipelined memory model plus a
// request-level reference (priority, block addresses, expected word contents).
module tb_mem_arbiter;
  localparam int MEM_LAT = 4;
  localparam int LAST    = 8 + MEM_LAT;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        d_wr_ack, i_fill_valid, d_fill_valid, i_fill_done, d_fill_done;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        busy, mem_en, mem_wr;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_data_valid;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .d_wr_ack(d_wr_ack),
    .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .fill_data(fill_data), .fill_word(fill_word), .busy(busy),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_data_valid(mem_data_valid)
  );

  // ---------------- memory model ----------------
  logic [15:0] salt;
  bit          written [0:32767];
  logic [15:0] wmem    [0:32767];
  logic        pv [1:MEM_LAT];
  logic [15:0] pd [1:MEM_LAT];
  logic        spur;

  function automatic logic [15:0] init_word(input logic [14:0] w);
    logic [15:0] t;
    t = {w, 1'b0} * 16'h9E37;
    return t ^ salt;
  endfunction

  assign mem_data_valid = pv[MEM_LAT] | spur;
  assign mem_data_out   = pd[MEM_LAT];

  always @(posedge clk) begin
    if (mem_en && mem_wr) begin
      written[mem_addr[15:1]] <= 1'b1;
      wmem[mem_addr[15:1]]    <= mem_data_in;
    end
    pv[1] <= mem_en && !mem_wr;
    pd[1] <= written[mem_addr[15:1]] ? wmem[mem_addr[15:1]] : init_word(mem_addr[15:1]);
    for (int i = 2; i <= MEM_LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end

  int n_ack = 0, n_done = 0;
  always @(posedge clk) begin
    if (d_wr_ack) n_ack++;
    if (i_fill_done || d_fill_done) n_done++;
  end

  // ---------------- reference model ----------------
  bit          ref_written [0:32767];
  logic [15:0] ref_wmem    [0:32767];
  bit          wr_pend = 0, d_pend = 0, i_pend = 0;
  logic [15:0] wr_a, wr_d, d_a, i_a;

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_written[a[15:1]] ? ref_wmem[a[15:1]] : init_word(a[15:1]);
  endfunction

  int n_cmp = 0, n_err = 0;

  task automatic check_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic adv(input bit s = 1'b0);
    @(posedge clk);
    #1 spur = s;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_b({tag, "_mem_en"}, mem_en, 1'b0);
    check_b({tag, "_mem_wr"}, mem_wr, 1'b0);
    check_w({tag, "_mem_addr"}, mem_addr, 16'h0000);
    check_w({tag, "_mem_data_in"}, mem_data_in, 16'h0000);
    check_b({tag, "_ack"}, d_wr_ack, 1'b0);
    check_b({tag, "_ivalid"}, i_fill_valid, 1'b0);
    check_b({tag, "_dvalid"}, d_fill_valid, 1'b0);
    check_b({tag, "_idone"}, i_fill_done, 1'b0);
    check_b({tag, "_ddone"}, d_fill_done, 1'b0);
    check_b({tag, "_busy"}, busy, 1'b0);
    check_w({tag, "_fill_word"}, 16'(fill_word), 16'h0000);
  endtask

  task automatic req_write(input logic [15:0] a, input logic [15:0] d);
    d_wr_req = 1'b1; d_wr_addr = a; d_wr_data = d;
    wr_pend = 1'b1; wr_a = a; wr_d = d;
  endtask

  task automatic req_d(input logic [15:0] a);
    d_miss = 1'b1; d_miss_addr = a; d_pend = 1'b1; d_a = a;
  endtask

  task automatic req_i(input logic [15:0] a);
    i_miss = 1'b1; i_miss_addr = a; i_pend = 1'b1; i_a = a;
  endtask

  // Called in an IDLE cycle with requests driven; returns in the next IDLE cycle
  // (or, when abort_at is hit, right after driving reset in that fill cycle).
  task automatic serve_next(input int abort_at, input bit spur_w);
    bit          own_d;
    logic [15:0] a, exp_addr;
    logic        exp_v;
    int          idx;
    check_b("idle_busy", busy, 1'b0);
    if (wr_pend) begin
      adv(spur_w);
      check_b("wr_en", mem_en, 1'b1);
      check_b("wr_wr", mem_wr, 1'b1);
      check_w("wr_addr", mem_addr, wr_a);
      check_w("wr_data", mem_data_in, wr_d);
      check_b("wr_ack", d_wr_ack, 1'b1);
      check_b("wr_busy", busy, 1'b1);
      check_b("wr_ivalid", i_fill_valid, 1'b0);
      check_b("wr_dvalid", d_fill_valid, 1'b0);
      d_wr_req = 1'b0;
      wr_pend  = 1'b0;
      ref_written[wr_a[15:1]] = 1'b1;
      ref_wmem[wr_a[15:1]]    = wr_d;
      adv();
      check_b("wr_after_busy", busy, 1'b0);
      check_b("wr_after_ack", d_wr_ack, 1'b0);
      check_b("wr_after_en", mem_en, 1'b0);
    end else if (d_pend || i_pend) begin
      own_d = d_pend;
      a = own_d ? d_a : i_a;
      for (int k = 1; k <= LAST; k++) begin
        adv();
        exp_v = (k > MEM_LAT);
        idx   = k - MEM_LAT - 1;
        check_b("fill_busy", busy, 1'b1);
        check_b("fill_wr", mem_wr, 1'b0);
        check_b("fill_en", mem_en, k <= 8);
        if (k <= 8) begin
          exp_addr = (a & 16'hFFF0) + 16'(2 * (k - 1));
          check_w("fill_addr", mem_addr, exp_addr);
        end
        check_b("fill_own_valid", own_d ? d_fill_valid : i_fill_valid, exp_v);
        check_b("fill_other_valid", own_d ? i_fill_valid : d_fill_valid, 1'b0);
        if (exp_v) begin
          check_w("fill_word", 16'(fill_word), 16'(idx));
          check_w("fill_data", fill_data, ref_read((a & 16'hFFF0) + 16'(2 * idx)));
        end
        check_b("fill_own_done", own_d ? d_fill_done : i_fill_done, k == LAST);
        check_b("fill_other_done", own_d ? i_fill_done : d_fill_done, 1'b0);
        check_b("fill_ack", d_wr_ack, 1'b0);
        if (k == abort_at) begin
          rst_n = 1'b0;
          i_miss = 1'b0; d_miss = 1'b0;
          i_pend = 1'b0; d_pend = 1'b0;
          return;
        end
        if (k == LAST) begin
          if (own_d) begin d_miss = 1'b0; d_pend = 1'b0; end
          else       begin i_miss = 1'b0; i_pend = 1'b0; end
        end
      end
      adv();
    end
  endtask

  // ---------------- stimulus ----------------
  int ack0, done0, idone0;

  initial begin
    rst_n = 1'b0; spur = 1'b0;
    i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    salt = 16'($urandom);
    repeat (6) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst_n = 1'b1;
    adv();

    // I fill of 0x1236: block 0x1230..0x123E.
    req_i(16'h1236);
    serve_next(0, 1'b0);

    // Store with a spurious mem_data_valid during the WRITE cycle.
    req_write(16'h0040, 16'hBEEF);
    serve_next(0, 1'b1);

    // Spurious mem_data_valid while idle.
    for (int i = 0; i < 3; i++) begin
      adv(1'b1);
      check_b("spur_idle_ivalid", i_fill_valid, 1'b0);
      check_b("spur_idle_dvalid", d_fill_valid, 1'b0);
      check_b("spur_idle_busy", busy, 1'b0);
    end
    adv();

    // Stored word must come back in a D fill of its block.
    req_d(16'h004A);
    serve_next(0, 1'b0);

    // D and I miss together: D first, I granted from the IDLE cycle after.
    req_d(16'h2000);
    req_i(16'h0100);
    serve_next(0, 1'b0);
    serve_next(0, 1'b0);

    // All three together: write, D fill, I fill.
    ack0 = n_ack; done0 = n_done;
    req_write(16'h2004, 16'($urandom));
    req_d(16'h2008);
    req_i(16'h2001);
    serve_next(0, 1'b0);
    serve_next(0, 1'b0);
    serve_next(0, 1'b0);
    check_w("three_way_acks", 16'(n_ack - ack0), 16'd1);
    check_w("three_way_dones", 16'(n_done - done0), 16'd2);

    // Reset during the 4th fill return.
    idone0 = n_done;
    req_i(16'h5678);
    serve_next(MEM_LAT + 4, 1'b0);
    adv();
    check_all_zero("abort");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      adv();
      check_b("stale_ivalid", i_fill_valid, 1'b0);
      check_b("stale_busy", busy, 1'b0);
    end
    check_w("abort_no_done", 16'(n_done - idone0), 16'd0);
    req_i(16'h5678);
    serve_next(0, 1'b0);

    // Randomized rounds over a small address window so stores hit filled blocks.
    for (int r = 0; r < 8; r++) begin
      int m;
      m = $urandom_range(1, 7);
      if (m[0]) req_write(16'h3000 | (16'($urandom) & 16'h00FE), 16'($urandom));
      if (m[1]) req_d(16'h3000 | (16'($urandom) & 16'h00FF));
      if (m[2]) req_i(16'h3000 | (16'($urandom) & 16'h00FF));
      while (wr_pend || d_pend || i_pend) serve_next(0, 1'($urandom_range(0, 1)));
    end
    req_d(16'h3000);
    serve_next(0, 1'b0);
    req_i(16'h3080);
    serve_next(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared-memory controller for the pipelined CPU. It arbitrates a single multi-cycle, pipelined main memory between the instruction-cache miss path, the data-cache miss path and write-through stores. It sequences 8-word block fills and returns each word to the requesting cache with its word index. It sits between the two cache controllers and the unified memory model, replacing the separate single-cycle instruction and data memories.

## Interface
- MEM_LAT, 4: cycles from a read issue (mem_en=1, mem_wr=0) to its mem_data_valid.
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- i_miss  in  1  instruction-cache fill request, level, held until i_fill_done
- i_miss_addr  in  16  byte address of missing I-block (bits [3:0] ignored)
- d_miss  in  1  data-cache fill request, level, held until d_fill_done
- d_miss_addr  in  16  byte address of missing D-block (bits [3:0] ignored)
- d_wr_req  in  1  store request, level, held until d_wr_ack
- d_wr_addr  in  16  store byte address
- d_wr_data  in  16  store data
- d_wr_ack  out  1  one-cycle pulse: store issued to memory
- i_fill_valid  out  1  fill_data is a word for the I-cache
- d_fill_valid  out  1  fill_data is a word for the D-cache
- i_fill_done  out  1  pulse coincident with last I fill word
- d_fill_done  out  1  pulse coincident with last D fill word
- fill_data  out  16  returned word (combinational pass of mem_data_out)
- fill_word  out  3  word index of fill_data within block
- busy  out  1  FSM not IDLE
- mem_en  out  1  memory access strobe (registered)
- mem_wr  out  1  1 = write (registered)
- mem_addr  out  16  memory byte address (registered)
- mem_data_in  out  16  write data to memory (registered)
- mem_data_out  in  16  read data from memory
- mem_data_valid  in  1  mem_data_out valid

## Operation
- States: IDLE, WRITE, FILL.
- IDLE: sample requests; priority d_wr_req > d_miss > i_miss. On grant latch address/data and owner (I or D), go WRITE or FILL. No request: stay IDLE.
- WRITE (1 cycle): mem_en=1, mem_wr=1, mem_addr=d_wr_addr latched, mem_data_in=d_wr_data latched; d_wr_ack=1; next IDLE.
- FILL: issue counter (3 bits) drives 8 back-to-back reads, mem_addr={base[15:4], issue_cnt, 1'b0}, issue_cnt 0..7, one per cycle; mem_en deasserts after the 8th. Return counter (3 bits) counts mem_data_valid pulses; fill_word=return counter; owner's fill_valid = mem_data_valid while in FILL. On 8th return (counter 7) pulse owner's fill_done, go IDLE.
- mem_data_valid outside FILL ignored; no fill_valid generated.
- Request deassertion mid-fill ignored; fill runs to completion.
- Memory writes never overlap outstanding reads (WRITE only entered from IDLE).
- Owner's non-asserted fill outputs stay 0; fill_data undefined when no fill_valid.

## Timing
- Reset (rst_n=0 at clock edge): state IDLE, counters 0, mem_en/mem_wr 0, mem_addr/mem_data_in 0x0000, all acks/valids/dones 0, busy 0. Reset mid-fill or mid-write aborts: no done/ack pulse, late mem_data_valid after reset ignored.
- Fill: request seen in IDLE cycle 0; mem_en cycles 1..8; fill_valid cycles 1+MEM_LAT..8+MEM_LAT; fill_done with last word; IDLE at 9+MEM_LAT; next grant decided that cycle, its first mem_en one cycle later.
- Write: req in IDLE cycle 0; mem_en/mem_wr and d_wr_ack cycle 1; IDLE cycle 2. Requester drops d_wr_req after ack; a still-high req at cycle 2 is a new store.
- busy=1 from cycle 1 through final FILL/WRITE cycle.
- Simultaneous d_wr_req, d_miss, i_miss: write, then D fill, then I fill; each in turn from IDLE.

## Test plan
- I fill, MEM_LAT=4, i_miss_addr=0x1236: mem_addr 0x1230,0x1232..0x123E cycles 1..8; i_fill_valid cycles 5..12, fill_word 0..7; i_fill_done cycle 12 only; d_* outputs 0.
- Store d_wr_addr=0x0040, data 0xBEEF: cycle 1 mem_en=1, mem_wr=1, mem_addr 0x0040, mem_data_in 0xBEEF, d_wr_ack=1; busy 0 cycle 2.
- d_miss (0x2000) and i_miss (0x0100) raised same cycle: D fill of 0x2000..0x200E completes with d_fill_done, then I fill of 0x0100..0x010E starts mem_en one cycle after return to IDLE.
- d_wr_req + d_miss + i_miss together: order write, D fill, I fill; exactly one ack, two dones.
- rst_n low during 4th fill return: outputs all 0 next cycle, no i_fill_done, stray mem_data_valid afterwards produces no fill_valid; new i_miss after reset refills from word 0.
- Spurious mem_data_valid in IDLE and during WRITE: no fill_valid, no state change.
